// File: rtl/disp_seq_pkg.sv
// Shared types and constants for the ASCII display sequencer.
//   state_t    : sequencer FSM states
//   entry_t    : one buffered character with its decimal-point request
//   BLANK_CHAR : code presented to the decoder while the digit is dark
//   timer_width: width of the shared dwell/gap down-counter
package disp_seq_pkg;

    localparam int unsigned CHAR_W = 8;

    localparam logic [CHAR_W-1:0] BLANK_CHAR = 8'h20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    typedef struct packed {
        logic              dp;
        logic [CHAR_W-1:0] ch;
    } entry_t;

    // Counter must hold the larger of the two reload values; never narrower than 1 bit.
    function automatic int unsigned timer_width(input int unsigned dwell, input int unsigned gap);
        int unsigned m;
        m = (dwell > gap) ? dwell : gap;
        return ($clog2(m) > 0) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/char_fifo.sv
// Circular character buffer for the display sequencer.
// Build option: ASCII_SEQ_REPEAT_EN replaces the next-entry peek output with a
// play-index input so the head read can walk the stored message without consuming it.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   clear          : synchronous flush, blocks any same-cycle push
//   push/push_entry: write request and data (accepted when wr_ready)
//   pop            : consume the head entry
//   play_idx       : (repeat build) offset from rd_ptr of the entry shown on head
//   next_entry     : (default build) entry one past the head
//   head           : entry at the current read position
//   wr_ready       : buffer can accept a write this cycle (combinational)
//   count          : number of stored entries
module char_fifo
    import disp_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    push,
    input  entry_t                  push_entry,
    input  logic                    pop,
`ifdef ASCII_SEQ_REPEAT_EN
    input  logic [$clog2(DEPTH)-1:0] play_idx,
`else
    output entry_t                  next_entry,
`endif
    output entry_t                  head,
    output logic                    wr_ready,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] head_idx;
    logic          do_push;
    logic          do_pop;

    assign wr_ready = (count < CW'(DEPTH)) && !clear;
    assign do_push  = push && wr_ready;
    assign do_pop   = pop && (count != '0) && !clear;

`ifdef ASCII_SEQ_REPEAT_EN
    assign head_idx = rd_ptr + play_idx;
`else
    logic [PW-1:0] next_idx;
    assign head_idx   = rd_ptr;
    assign next_idx   = rd_ptr + PW'(1);
    assign next_entry = mem[next_idx];
`endif

    assign head = mem[head_idx];

    // Storage array: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ascii_display_sequencer.sv
// Plays buffered ASCII characters one at a time on a single 7-segment digit:
// each character is shown for DWELL_CYCLES, followed by GAP_CYCLES of blank digit.
// Build option: ASCII_SEQ_REPEAT_EN loops the stored message instead of consuming it.
// Ports:
//   clk50MHz, rst : clock, synchronous active-high reset
//   clear         : flush buffer and return to IDLE
//   wr_valid/wr_char/wr_dp/wr_ready : host write handshake
//   ascii_out, dp_out, blank        : registered decoder controls
//   busy          : sequencer not idle
//   count         : buffered entries
module ascii_display_sequencer
    import disp_seq_pkg::*;
#(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned DWELL_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES   = 5_000_000
) (
    input  logic                    clk50MHz,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    wr_valid,
    input  logic [CHAR_W-1:0]       wr_char,
    input  logic                    wr_dp,
    output logic                    wr_ready,
    output logic [CHAR_W-1:0]       ascii_out,
    output logic                    dp_out,
    output logic                    blank,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = timer_width(DWELL_CYCLES, GAP_CYCLES);

    localparam logic [TW-1:0] DWELL_LOAD = TW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    state_t            state_q;
    state_t            state_d;
    logic [TW-1:0]     timer_q;
    logic [TW-1:0]     timer_d;
    logic [CHAR_W-1:0] ascii_d;
    logic              dp_d;
    logic              blank_d;
    logic              pop;
    entry_t            head;
    entry_t            push_entry;

    assign push_entry = '{dp: wr_dp, ch: wr_char};
    assign busy       = (state_q != IDLE);

`ifdef ASCII_SEQ_REPEAT_EN
    logic [PW-1:0] play_q;
    logic [PW-1:0] play_d;
    logic [PW-1:0] play_adv;
    logic [PW-1:0] play_sel;

    // Next play position, wrapping at the current message length.
    assign play_adv = ((CW'(play_q) + CW'(1)) >= count) ? '0 : (play_q + PW'(1));
    // Back-to-back playback must read the advanced slot in the completion cycle.
    assign play_sel = ((GAP_CYCLES == 0) && (state_q == SHOW) && (timer_q == '0))
                      ? play_adv : play_q;

    char_fifo #(
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk50MHz),
        .rst        (rst),
        .clear      (clear),
        .push       (wr_valid),
        .push_entry (push_entry),
        .pop        (pop),
        .play_idx   (play_sel),
        .head       (head),
        .wr_ready   (wr_ready),
        .count      (count)
    );
`else
    entry_t next_entry;

    char_fifo #(
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk50MHz),
        .rst        (rst),
        .clear      (clear),
        .push       (wr_valid),
        .push_entry (push_entry),
        .pop        (pop),
        .next_entry (next_entry),
        .head       (head),
        .wr_ready   (wr_ready),
        .count      (count)
    );
`endif

    // State, timer and decoder output registers.
    always_ff @(posedge clk50MHz) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            ascii_out <= BLANK_CHAR;
            dp_out    <= 1'b0;
            blank     <= 1'b1;
`ifdef ASCII_SEQ_REPEAT_EN
            play_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            ascii_out <= ascii_d;
            dp_out    <= dp_d;
            blank     <= blank_d;
`ifdef ASCII_SEQ_REPEAT_EN
            play_q    <= play_d;
`endif
        end
    end

    // Next-state, timer reload and output selection.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        ascii_d = ascii_out;
        dp_d    = dp_out;
        blank_d = blank;
        pop     = 1'b0;
`ifdef ASCII_SEQ_REPEAT_EN
        play_d  = play_q;
`endif

        case (state_q)
            IDLE: begin
                ascii_d = BLANK_CHAR;
                dp_d    = 1'b0;
                blank_d = 1'b1;
                timer_d = '0;
                if (count != '0) begin
                    state_d = SHOW;
                    timer_d = DWELL_LOAD;
                    ascii_d = head.ch;
                    dp_d    = head.dp;
                    blank_d = 1'b0;
                end
            end

            SHOW: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else begin
`ifdef ASCII_SEQ_REPEAT_EN
                    play_d = play_adv;
`else
                    pop    = 1'b1;
`endif
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        timer_d = GAP_LOAD;
                        ascii_d = BLANK_CHAR;
                        dp_d    = 1'b0;
                        blank_d = 1'b1;
                    end else begin
`ifdef ASCII_SEQ_REPEAT_EN
                        // Message never drains; head already points at play_adv.
                        state_d = SHOW;
                        timer_d = DWELL_LOAD;
                        ascii_d = head.ch;
                        dp_d    = head.dp;
                        blank_d = 1'b0;
`else
                        // Head is being popped this cycle, so the follower is next_entry.
                        if (count > CW'(1)) begin
                            state_d = SHOW;
                            timer_d = DWELL_LOAD;
                            ascii_d = next_entry.ch;
                            dp_d    = next_entry.dp;
                            blank_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                            timer_d = '0;
                            ascii_d = BLANK_CHAR;
                            dp_d    = 1'b0;
                            blank_d = 1'b1;
                        end
`endif
                    end
                end
            end

            GAP: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else if (count != '0) begin
                    state_d = SHOW;
                    timer_d = DWELL_LOAD;
                    ascii_d = head.ch;
                    dp_d    = head.dp;
                    blank_d = 1'b0;
                end else begin
                    state_d = IDLE;
                    timer_d = '0;
                    ascii_d = BLANK_CHAR;
                    dp_d    = 1'b0;
                    blank_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                timer_d = '0;
                ascii_d = BLANK_CHAR;
                dp_d    = 1'b0;
                blank_d = 1'b1;
            end
        endcase

        // Flush wins over everything except reset.
        if (clear) begin
            state_d = IDLE;
            timer_d = '0;
            ascii_d = BLANK_CHAR;
            dp_d    = 1'b0;
            blank_d = 1'b1;
            pop     = 1'b0;
`ifdef ASCII_SEQ_REPEAT_EN
            play_d  = '0;
`endif
        end
    end

endmodule

// File: tb/tb_ascii_display_sequencer.sv
// Bench for ascii_display_sequencer (DEPTH=4, DWELL=4, GAP=2).
// Stimulus pushes each character expected to play into a queue; the monitor
// measures every displayed run and gap and pops the queue to compare.
module tb_ascii_display_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DWELL = 4;
    localparam int unsigned GAP   = 2;

    typedef struct {
        logic [7:0] ch;
        logic       dp;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_char = 8'h00;
    logic       wr_dp = 1'b0;
    logic       wr_ready;
    logic [7:0] ascii_out;
    logic       dp_out;
    logic       blank;
    logic       busy;
    logic [2:0] count;

    int tests = 0;
    int fails = 0;

    exp_t exp_q[$];

    logic       in_show = 1'b0;
    logic       in_gap = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] cur_ch = 8'h00;
    logic       cur_dp = 1'b0;
    int         run = 0;
    int         gap_run = 0;
    int         show_done = 0;

    ascii_display_sequencer #(
        .DEPTH        (DEPTH),
        .DWELL_CYCLES (DWELL),
        .GAP_CYCLES   (GAP)
    ) dut (
        .clk50MHz  (clk),
        .rst       (rst),
        .clear     (clear),
        .wr_valid  (wr_valid),
        .wr_char   (wr_char),
        .wr_dp     (wr_dp),
        .wr_ready  (wr_ready),
        .ascii_out (ascii_out),
        .dp_out    (dp_out),
        .blank     (blank),
        .busy      (busy),
        .count     (count)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic finish_show();
        exp_t e;
        in_show = 1'b0;
        show_done++;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_extra: got char %0h, required none at %0t", cur_ch, $time);
        end else begin
            e = exp_q.pop_front();
            check("sb_char", 32'(cur_ch), 32'(e.ch));
            check("sb_dp", 32'(cur_dp), 32'(e.dp));
            check("sb_dwell", 32'(run), 32'(DWELL));
        end
    endtask

    task automatic finish_gap();
        in_gap = 1'b0;
        check("sb_gap", 32'(gap_run), 32'(GAP));
    endtask

    // Reset or flush truncates whatever run is in progress.
    always @(posedge clk) begin
        if (rst || clear) abort = 1'b1;
    end

    // Monitor: segments the display into shown runs and gaps.
    always @(negedge clk) begin
        if (abort) begin
            abort   = 1'b0;
            in_show = 1'b0;
            in_gap  = 1'b0;
            run     = 0;
            gap_run = 0;
        end else if (blank === 1'b0) begin
            if (in_show && ascii_out == cur_ch && dp_out == cur_dp) begin
                run++;
            end else begin
                if (in_show) finish_show();
                if (in_gap) finish_gap();
                in_show = 1'b1;
                cur_ch  = ascii_out;
                cur_dp  = dp_out;
                run     = 1;
            end
        end else if (blank === 1'b1 && busy === 1'b1) begin
            if (in_show) finish_show();
            if (!in_gap) begin
                in_gap  = 1'b1;
                gap_run = 0;
            end
            gap_run++;
        end else if (blank === 1'b1) begin
            if (in_show) finish_show();
            if (in_gap) finish_gap();
        end
    end

    // Drive one character for one rising edge; called at a falling edge.
    task automatic write_char(input logic [7:0] c, input logic d);
        wr_valid = 1'b1;
        wr_char  = c;
        wr_dp    = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic expect_char(input logic [7:0] c, input logic d);
        exp_t e;
        e.ch = c;
        e.dp = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_values();
        check("rst_ascii", 32'(ascii_out), 32'h20);
        check("rst_dp", 32'(dp_out), 32'd0);
        check("rst_blank", 32'(blank), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_values();

`ifdef ASCII_SEQ_REPEAT_EN
        // Looping message "12": three full loops, then flush during a gap.
        repeat (2) @(negedge clk);
        show_done = 0;
        for (int k = 0; k < 3; k++) begin
            expect_char(8'h31, 1'b0);
            expect_char(8'h32, 1'b0);
        end
        write_char(8'h31, 1'b0);
        write_char(8'h32, 1'b0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (show_done >= 6) break;
        end
        check("rep_loops", 32'(show_done >= 6), 32'd1);
        check("rep_count", 32'(count), 32'd2);
        check("rep_busy", 32'(busy), 32'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_q.delete();
        check("rep_clr_busy", 32'(busy), 32'd0);
        check("rep_clr_count", 32'(count), 32'd0);
        check("rep_clr_blank", 32'(blank), 32'd1);
        repeat (8) @(negedge clk);
        check("rep_stay_idle", 32'(busy), 32'd0);
`else
        // Single character with decimal point: visible from the edge after acceptance.
        @(negedge clk);
        expect_char(8'h41, 1'b1);
        write_char(8'h41, 1'b1);
        check("a_count", 32'(count), 32'd1);
        check("a_not_yet", 32'(blank), 32'd1);
        @(negedge clk);
        check("a_ascii", 32'(ascii_out), 32'h41);
        check("a_dp", 32'(dp_out), 32'd1);
        check("a_blank", 32'(blank), 32'd0);
        check("a_busy", 32'(busy), 32'd1);
        wait_idle("a_idle");
        check("a_count_end", 32'(count), 32'd0);

        // Fill with "HELP"; a fifth write while full is ignored.
        expect_char(8'h48, 1'b0);
        expect_char(8'h45, 1'b0);
        expect_char(8'h4C, 1'b0);
        expect_char(8'h50, 1'b0);
        write_char(8'h48, 1'b0);
        write_char(8'h45, 1'b0);
        write_char(8'h4C, 1'b0);
        write_char(8'h50, 1'b0);
        check("full_count", 32'(count), 32'd4);
        check("full_ready", 32'(wr_ready), 32'd0);
        write_char(8'h58, 1'b0);
        check("full_ignored", 32'(count), 32'd4);
        @(negedge clk);
        check("consume_count", 32'(count), 32'd3);
        check("consume_gap", 32'(blank), 32'd1);
        wait_idle("help_idle");
        check("help_count_end", 32'(count), 32'd0);

        // Write landing on the completion edge: count holds at 3.
        expect_char(8'h57, 1'b0);
        expect_char(8'h58, 1'b0);
        expect_char(8'h59, 1'b0);
        expect_char(8'h5A, 1'b0);
        write_char(8'h57, 1'b0);
        write_char(8'h58, 1'b0);
        write_char(8'h59, 1'b0);
        check("wc_count3", 32'(count), 32'd3);
        repeat (2) @(negedge clk);
        check("wc_pre_count", 32'(count), 32'd3);
        check("wc_pre_show", 32'(blank), 32'd0);
        write_char(8'h5A, 1'b0);
        check("wc_post_count", 32'(count), 32'd3);
        check("wc_post_gap", 32'(blank), 32'd1);
        wait_idle("wc_idle");

        // Flush together with a write mid-show.
        expect_char(8'h43, 1'b0);
        expect_char(8'h44, 1'b0);
        write_char(8'h43, 1'b0);
        write_char(8'h44, 1'b0);
        @(negedge clk);
        clear    = 1'b1;
        wr_valid = 1'b1;
        wr_char  = 8'h51;
        #1;
        check("clr_ready", 32'(wr_ready), 32'd0);
        @(negedge clk);
        clear    = 1'b0;
        wr_valid = 1'b0;
        exp_q.delete();
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_count", 32'(count), 32'd0);
        check("clr_blank", 32'(blank), 32'd1);
        check("clr_ascii", 32'(ascii_out), 32'h20);
        repeat (3) @(negedge clk);
        check("clr_dropped", 32'(count), 32'd0);
        check("clr_stay_idle", 32'(busy), 32'd0);

        // Reset during the gap, then a write one cycle after release.
        expect_char(8'h52, 1'b0);
        write_char(8'h52, 1'b0);
        repeat (5) @(negedge clk);
        check("rg_in_gap", 32'(blank & busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check_reset_values();
        @(negedge clk);
        expect_char(8'h53, 1'b0);
        write_char(8'h53, 1'b0);
        check("rg_not_yet", 32'(blank), 32'd1);
        @(negedge clk);
        check("rg_ascii", 32'(ascii_out), 32'h53);
        check("rg_blank", 32'(blank), 32'd0);
        wait_idle("rg_idle");
`endif

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
